// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcode encodings and immediate-format tags.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LOAD     = 7'h03;
    localparam logic [6:0] OP_MISC_MEM = 7'h0F;
    localparam logic [6:0] OP_IMM      = 7'h13;
    localparam logic [6:0] OP_AUIPC    = 7'h17;
    localparam logic [6:0] OP_STORE    = 7'h23;
    localparam logic [6:0] OP_REG      = 7'h33;
    localparam logic [6:0] OP_LUI      = 7'h37;
    localparam logic [6:0] OP_BRANCH   = 7'h63;
    localparam logic [6:0] OP_JALR     = 7'h67;
    localparam logic [6:0] OP_JAL      = 7'h6F;
    localparam logic [6:0] OP_SYSTEM   = 7'h73;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

endpackage

// File: rtl/idu_queue_if.sv
// IFU -> IDU -> EXU boundary of the decode queue, plus occupancy and decode results.
interface idu_queue_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 2
) ();
    import rv32_pkg::*;

    // Handshake: a transfer happens on a rising clock edge where valid && ready.
    // Ready/valid driven by the queue depend only on its registered state.
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       inst_in;
    logic [XLEN-1:0]   pc_in;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   pc_out;
    logic [6:0]        op;
    logic [2:0]        func;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [31:0]       imm;
    logic              reg_wen;
    logic              illegal;
    logic [CNT_W-1:0]  count;
    imm_type_e         imm_type;

    modport master (
        output in_valid, inst_in, pc_in, flush, out_ready,
        input  in_ready, out_valid, pc_out, op, func, rs1, rs2, rd,
               imm, reg_wen, illegal, count, imm_type
    );

    modport slave (
        input  in_valid, inst_in, pc_in, flush, out_ready,
        output in_ready, out_valid, pc_out, op, func, rs1, rs2, rd,
               imm, reg_wen, illegal, count, imm_type
    );

endinterface

// File: rtl/idu_imm_gen.sv
// Combinational RV32I immediate generator, write-enable and illegal-opcode classifier.
module idu_imm_gen
    import rv32_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm,
    output imm_type_e   imm_type,
    output logic        reg_wen,
    output logic        illegal
);

    always_comb begin
        imm_type = IMM_NONE;
        reg_wen  = 1'b0;
        illegal  = 1'b0;
        case (inst[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
                imm_type = IMM_I;
                reg_wen  = 1'b1;
            end
            OP_STORE:  imm_type = IMM_S;
            OP_BRANCH: imm_type = IMM_B;
            OP_LUI, OP_AUIPC: begin
                imm_type = IMM_U;
                reg_wen  = 1'b1;
            end
            OP_JAL: begin
                imm_type = IMM_J;
                reg_wen  = 1'b1;
            end
            OP_REG:      reg_wen = 1'b1;
            OP_MISC_MEM: imm_type = IMM_NONE;
            default:     illegal = 1'b1;
        endcase
        // Compressed/reserved low bits are never a legal 32-bit encoding.
        if (inst[1:0] != 2'b11) begin
            illegal  = 1'b1;
            imm_type = IMM_NONE;
            reg_wen  = 1'b0;
        end
    end

    always_comb begin
        imm = 32'h0;
        case (imm_type)
            IMM_I: imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U: imm = {inst[31:12], 12'h000};
            IMM_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
    end

endmodule

// File: rtl/idu_queue.sv
// Instruction decode queue: DEPTH-entry FIFO between IFU and EXU, decoding the head entry.
module idu_queue
    import rv32_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        clock,
    input  logic        reset,
    idu_queue_if.slave  q
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      inst_mem_q [DEPTH];
    logic [XLEN-1:0]  pc_mem_q   [DEPTH];

    logic full, empty, push, pop;
    logic [31:0] head_inst;
    logic        dec_reg_wen, dec_illegal;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    // Flush wins over both sides: nothing is written or retired on a redirect edge.
    assign push  = q.in_valid && !full && !q.flush;
    assign pop   = !empty && q.out_ready && !q.flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (q.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= q.inst_in;
            pc_mem_q[wr_ptr_q]   <= q.pc_in;
        end
    end

    assign head_inst = inst_mem_q[rd_ptr_q];

    idu_imm_gen u_imm_gen (
        .inst     (head_inst),
        .imm      (q.imm),
        .imm_type (q.imm_type),
        .reg_wen  (dec_reg_wen),
        .illegal  (dec_illegal)
    );

    assign q.in_ready  = !full;
    assign q.out_valid = !empty;
    assign q.count     = count_q;
    assign q.pc_out    = pc_mem_q[rd_ptr_q];
    assign q.op        = head_inst[6:0];
    assign q.func      = head_inst[14:12];
    assign q.rs1       = head_inst[19:15];
    assign q.rs2       = head_inst[24:20];
    assign q.rd        = head_inst[11:7];
    // Side-effect flags must not leak from stale storage when the head is empty.
    assign q.reg_wen   = dec_reg_wen && !empty;
    assign q.illegal   = dec_illegal && !empty;

endmodule

// File: tb/tb_idu_queue.sv
// Directed bench for idu_queue (DEPTH=2): decode, backpressure, streaming, flush, async reset.
module tb_idu_queue;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] exp_q [$];

    idu_queue_if #(.XLEN(32), .CNT_W(2)) qif ();

    idu_queue #(.XLEN(32), .DEPTH(2), .CNT_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .q     (qif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1ns after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        qif.in_valid  = v;
        qif.inst_in   = inst;
        qif.pc_in     = pc;
        qif.out_ready = rdy;
        qif.flush     = fl;
    endtask

    task automatic decode_one(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                              input logic [31:0] e_imm, input logic e_wen, input logic e_ill);
        drive(1'b1, inst, pc, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk({tag, "_valid"}, 32'(qif.out_valid), 32'd1);
        chk({tag, "_pc"}, qif.pc_out, pc);
        chk({tag, "_imm"}, qif.imm, e_imm);
        chk({tag, "_wen"}, 32'(qif.reg_wen), 32'(e_wen));
        chk({tag, "_ill"}, 32'(qif.illegal), 32'(e_ill));
        step();
        chk({tag, "_popped"}, 32'(qif.out_valid), 32'd0);
        chk({tag, "_gate_wen"}, 32'(qif.reg_wen), 32'd0);
        chk({tag, "_gate_ill"}, 32'(qif.illegal), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #3;
        chk("rst_count", 32'(qif.count), 32'd0);
        chk("rst_in_ready", 32'(qif.in_ready), 32'd1);
        chk("rst_out_valid", 32'(qif.out_valid), 32'd0);
        step();
        step();
        reset = 1'b0;

        // addi x1,x0,-1
        drive(1'b1, 32'hFFF00093, 32'h0000_1000, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("addi_valid", 32'(qif.out_valid), 32'd1);
        chk("addi_rd", 32'(qif.rd), 32'd1);
        chk("addi_rs1", 32'(qif.rs1), 32'd0);
        chk("addi_op", 32'(qif.op), 32'h13);
        chk("addi_imm", qif.imm, 32'hFFFFFFFF);
        chk("addi_wen", 32'(qif.reg_wen), 32'd1);
        chk("addi_ill", 32'(qif.illegal), 32'd0);
        chk("addi_count", 32'(qif.count), 32'd1);
        step();
        chk("addi_popped", 32'(qif.out_valid), 32'd0);
        chk("addi_count0", 32'(qif.count), 32'd0);

        decode_one("sw",   32'h0020A423, 32'h0000_1004, 32'h00000008, 1'b0, 1'b0);
        decode_one("beq",  32'hFE000EE3, 32'h0000_1008, 32'hFFFFFFFC, 1'b0, 1'b0);
        decode_one("jal",  32'h001000EF, 32'h0000_100C, 32'h00000800, 1'b1, 1'b0);
        decode_one("lui",  32'h123452B7, 32'h0000_1010, 32'h12345000, 1'b1, 1'b0);
        decode_one("zero", 32'h00000000, 32'h0000_1014, 32'h00000000, 1'b0, 1'b1);
        decode_one("zero2", 32'h00000000, 32'h0000_1018, 32'h00000000, 1'b0, 1'b1);

        // Backpressure: three pushes into a 2-deep queue with EXU stalled
        drive(1'b1, 32'h00100093, 32'h0000_2000, 1'b0, 1'b0);
        step();
        chk("bp_count1", 32'(qif.count), 32'd1);
        chk("bp_ready1", 32'(qif.in_ready), 32'd1);
        drive(1'b1, 32'h00200093, 32'h0000_2004, 1'b0, 1'b0);
        step();
        chk("bp_count2", 32'(qif.count), 32'd2);
        chk("bp_ready2", 32'(qif.in_ready), 32'd0);
        drive(1'b1, 32'h00300093, 32'h0000_2008, 1'b0, 1'b0);
        step();
        chk("bp_held_count", 32'(qif.count), 32'd2);
        chk("bp_head_pc", qif.pc_out, 32'h0000_2000);
        drive(1'b1, 32'h00300093, 32'h0000_2008, 1'b1, 1'b0);
        step();
        chk("bp_drain1_count", 32'(qif.count), 32'd1);
        chk("bp_drain1_pc", qif.pc_out, 32'h0000_2004);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("bp_third_count", 32'(qif.count), 32'd1);
        chk("bp_third_pc", qif.pc_out, 32'h0000_2008);
        chk("bp_third_imm", qif.imm, 32'd3);
        step();
        chk("bp_empty", 32'(qif.count), 32'd0);

        // Streaming with sequential PCs
        exp_q.delete();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h00000013, 32'h0000_3000 + 32'(4 * k), 1'b1, 1'b0);
            exp_q.push_back(32'h0000_3000 + 32'(4 * k));
            step();
            if (exp_q.size() > 1) void'(exp_q.pop_front());
            chk("stream_pc", qif.pc_out, exp_q[0]);
            chk("stream_count", 32'(qif.count), 32'd1);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        chk("stream_end", 32'(qif.count), 32'd0);

        // Flush while full with a same-cycle push
        drive(1'b1, 32'h00000013, 32'h0000_4000, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h00000013, 32'h0000_4004, 1'b0, 1'b0);
        step();
        chk("fl_full", 32'(qif.count), 32'd2);
        drive(1'b1, 32'h00000013, 32'h0000_4008, 1'b1, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("fl_count", 32'(qif.count), 32'd0);
        chk("fl_out_valid", 32'(qif.out_valid), 32'd0);
        chk("fl_in_ready", 32'(qif.in_ready), 32'd1);
        step();
        chk("fl_still_empty", 32'(qif.out_valid), 32'd0);
        drive(1'b1, 32'h00000013, 32'h0000_5000, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("fl_next_pc", qif.pc_out, 32'h0000_5000);
        step();

        // Asynchronous reset between edges with two entries queued
        drive(1'b1, 32'h00000013, 32'h0000_6000, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h00000013, 32'h0000_6004, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("ar_full", 32'(qif.count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_count", 32'(qif.count), 32'd0);
        chk("ar_out_valid", 32'(qif.out_valid), 32'd0);
        chk("ar_in_ready", 32'(qif.in_ready), 32'd1);
        #1;
        reset = 1'b0;
        drive(1'b1, 32'h00000013, 32'h0000_7000, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("ar_first_pc", qif.pc_out, 32'h0000_7000);
        chk("ar_first_count", 32'(qif.count), 32'd1);
        step();
        chk("ar_drained", 32'(qif.count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/idu_queue.md
Name: idu_queue

Overview:
- Next-generation instruction decode stage for the RV32I core, sitting between IFU and EXU.
- Replaces the single-register IDU with a parametrised DEPTH-entry instruction queue using full valid/ready handshakes on both sides.
- Supports synchronous flush on redirect (jump/branch/trap).
- Provides complete RV32I immediate generation plus illegal-opcode detection, decoded from the queue head.

Parameters:
- XLEN, 32, datapath/PC width (only 32 supported; parameter kept for package consistency)
- DEPTH, 2, queue entries; power of two, >= 2
- CNT_W, $clog2(DEPTH)+1, width of occupancy count

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  IFU offers inst_in/pc_in
- in_ready  out  1  queue can accept (= !full)
- inst_in  in  32  fetched instruction
- pc_in  in  XLEN  PC of inst_in
- flush  in  1  redirect; discard all queued and incoming entries
- out_valid  out  1  head entry valid (= !empty)
- out_ready  in  1  EXU consumes head
- pc_out  out  XLEN  PC of head
- op  out  7  head inst[6:0]
- func  out  3  head inst[14:12]
- rs1, rs2, rd  out  5 each  head register fields
- imm  out  32  sign-extended immediate for head
- reg_wen  out  1  head writes rd
- illegal  out  1  head is not a supported RV32I encoding
- count  out  CNT_W  current occupancy

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high (clock, reset).
- Reset state: rd_ptr = wr_ptr = 0, count = 0, so in_ready = 1 and out_valid = 0. Storage array is not reset.
- Push: on posedge when in_valid && in_ready && !flush, write {inst_in, pc_in} at wr_ptr; wr_ptr wraps modulo DEPTH.
- Pop: on posedge when out_valid && out_ready && !flush, advance rd_ptr, wrapping modulo DEPTH.
- Simultaneous push and pop:
  - Allowed whenever not full; count is unchanged.
  - When full, in_ready = 0, so there is no same-cycle push even if a pop occurs (no ready bypass; in_ready is registered-state derived only).
- Latency: no fall-through. An entry accepted at edge N is presented with out_valid = 1 after edge N. Minimum latency is 1 cycle; throughput is 1 instruction per cycle.
- Flush:
  - Synchronous and highest priority.
  - At the edge where flush = 1: pointers and count go to 0, and any same-cycle push and pop are both discarded.
  - out_valid = 0 and in_ready = 1 in the following cycle.
- Full condition: count == DEPTH. Empty condition: count == 0.
- in_ready and out_valid depend only on registered state, never combinationally on in_valid or out_ready.
- Decode is purely combinational from the head entry (inst = head instruction):
  - I-type (opcodes 03, 13, 67, 73): imm = sext(inst[31:20])
  - S-type (23): imm = sext({inst[31:25], inst[11:7]})
  - B-type (63): imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})
  - U-type (37, 17): imm = {inst[31:12], 12'b0}
  - J-type (6F): imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})
  - R-type (33), FENCE (0F), and illegal encodings: imm = 0
- illegal = 1 when inst[1:0] != 2'b11, or when the opcode is outside {03, 0F, 13, 17, 23, 33, 37, 63, 67, 6F, 73}.
- reg_wen = 1 for opcodes 03, 13, 17, 33, 37, 67, 6F, 73. reg_wen = 0 for S, B, FENCE, and illegal encodings.
- Output gating: when out_valid = 0, reg_wen and illegal are forced to 0. All other decoded outputs are don't-care and may show stale storage.
- Reset mid-operation: all queued entries are lost immediately (asynchronous); no output glitch requirements beyond the reset values above.

Decomposition:
- Shared package rv32_pkg:
  - opcode localparams (OP_LOAD, OP_MISC_MEM, OP_IMM, OP_AUIPC, OP_STORE, OP_REG, OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM)
  - imm_type enum {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J}
- Sub-module idu_imm_gen: combinational; inst in; imm, imm_type, reg_wen, illegal out.
- idu_queue holds the FIFO pointers, count, storage, and handshake logic.

Test Plan:
- Single instruction 0xFFF00093 (addi x1,x0,-1), out_ready = 1 -> one cycle later out_valid = 1, rd = 1, rs1 = 0, imm = 0xFFFFFFFF, reg_wen = 1, illegal = 0; popped next edge.
- Immediate sweep:
  - 0x0020A423 (sw) -> imm = 0x00000008, reg_wen = 0
  - 0xFE000EE3 (beq -4) -> imm = 0xFFFFFFFC, reg_wen = 0
  - 0x001000EF (jal x1, +2048) -> imm = 0x00000800, reg_wen = 1
  - 0x123452B7 (lui) -> imm = 0x12345000
  - 0x00000000 -> illegal = 1, reg_wen = 0
- DEPTH = 2, out_ready = 0, three back-to-back pushes -> count goes 1, 2; in_ready = 0 after second accept; third held. Then out_ready = 1 -> entries drain in order with matching pc_out; third accepted only after count < 2.
- Streaming: in_valid = out_ready = 1 for 10 cycles with sequential PCs -> count stays 1, one instruction out per cycle, no PC skipped or duplicated.
- Flush with queue full and in_valid = 1 in the same cycle -> next cycle count = 0, out_valid = 0, in_ready = 1; the flushed and incoming instructions never appear at the output.
- Assert reset asynchronously between clock edges with count = 2 -> out_valid = 0, count = 0, in_ready = 1 immediately; after deassertion the next push is the first instruction output.
